// File: rtl/game_ctl.sv
// Air-hockey frame sequencer: moves the puck once per frame, resolves goal, paddle
// and wall events, keeps both scores and runs the serve/play/game-over flow.
module game_ctl #(
   parameter int FIELD_X_MIN  = 32,
   parameter int FIELD_X_MAX  = 991,
   parameter int FIELD_Y_MIN  = 32,
   parameter int FIELD_Y_MAX  = 735,
   parameter int GOAL_Y_MIN   = 304,
   parameter int GOAL_Y_MAX   = 463,
   parameter int BALL_R       = 10,
   parameter int PLAYER_R     = 20,
   parameter int SPEED        = 4,
   parameter int SERVE_FRAMES = 60,
   parameter int WIN_SCORE    = 7
) (
   input  logic        clk_in,
   input  logic        rst,
   input  logic        vblnk_in,
   input  logic        start,
   input  logic [11:0] xpos_in,
   input  logic [11:0] ypos_in,
   output logic [11:0] ball_xpos,
   output logic [11:0] ball_ypos,
   output logic [3:0]  score_p1,
   output logic [3:0]  score_p2,
   output logic [2:0]  state,
   output logic        frame_tick
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      SERVE = 3'd1,
      PLAY  = 3'd2,
      GOAL  = 3'd3,
      OVER  = 3'd4
   } state_t;

   localparam logic signed [12:0] X_LO  = 13'(FIELD_X_MIN + BALL_R);
   localparam logic signed [12:0] X_HI  = 13'(FIELD_X_MAX - BALL_R);
   localparam logic signed [12:0] Y_LO  = 13'(FIELD_Y_MIN + BALL_R);
   localparam logic signed [12:0] Y_HI  = 13'(FIELD_Y_MAX - BALL_R);
   localparam logic signed [12:0] REACH = 13'(BALL_R + PLAYER_R);
   localparam logic signed [12:0] SPD   = 13'(SPEED);
   localparam logic [11:0] G_LO = 12'(GOAL_Y_MIN);
   localparam logic [11:0] G_HI = 12'(GOAL_Y_MAX);
   localparam logic [11:0] CX   = 12'd512;
   localparam logic [11:0] CY   = 12'd384;
   localparam logic [3:0]  WIN  = 4'(WIN_SCORE);
   localparam int CNT_W = $clog2(SERVE_FRAMES + 1);
   localparam logic [CNT_W-1:0] SERVE_LAST = CNT_W'(SERVE_FRAMES - 1);

   state_t            state_q;
   logic [11:0]       ballX_q, ballY_q;
   logic signed [12:0] vx_q, vy_q;
   logic [3:0]        scoreP1_q, scoreP2_q;
   logic [CNT_W-1:0]  serveCnt_q;
   logic              serveNeg_q;
   logic              vblnkPrev_q;
   logic              frameTick_q;

   logic               tick;
   logic               inBand;
   logic               hitPaddle;
   logic signed [12:0] nextX, nextY, dx, dy, adx, ady;

   assign tick      = vblnk_in & ~vblnkPrev_q;
   assign nextX     = $signed({1'b0, ballX_q}) + vx_q;
   assign nextY     = $signed({1'b0, ballY_q}) + vy_q;
   assign dx        = nextX - $signed({1'b0, xpos_in});
   assign dy        = nextY - $signed({1'b0, ypos_in});
   assign adx       = dx[12] ? -dx : dx;
   assign ady       = dy[12] ? -dy : dy;
   assign inBand    = (ballY_q >= G_LO) && (ballY_q <= G_HI);
   assign hitPaddle = (adx <= REACH) && (ady <= REACH);

   function automatic logic [3:0] satInc(input logic [3:0] s);
      return (s >= WIN) ? s : s + 4'd1;
   endfunction

   // Goal beats paddle beats walls; a paddle hit only redirects, the puck stays put that frame.
   always_ff @(posedge clk_in or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         ballX_q     <= CX;
         ballY_q     <= CY;
         vx_q        <= '0;
         vy_q        <= '0;
         scoreP1_q   <= '0;
         scoreP2_q   <= '0;
         serveCnt_q  <= '0;
         serveNeg_q  <= 1'b0;
         vblnkPrev_q <= 1'b1;
         frameTick_q <= 1'b0;
      end else begin
         vblnkPrev_q <= vblnk_in;
         frameTick_q <= tick;
         case (state_q)
            IDLE: begin
               if (start) begin
                  state_q    <= SERVE;
                  serveCnt_q <= '0;
               end
            end
            SERVE: begin
               if (tick) begin
                  if (serveCnt_q == SERVE_LAST) begin
                     state_q <= PLAY;
                     vx_q    <= serveNeg_q ? -SPD : SPD;
                     vy_q    <= SPD;
                  end else begin
                     serveCnt_q <= serveCnt_q + 1'b1;
                  end
               end
            end
            PLAY: begin
               if (tick) begin
                  if (nextX <= X_LO && inBand) begin
                     scoreP2_q  <= satInc(scoreP2_q);
                     serveNeg_q <= 1'b1;
                     state_q    <= GOAL;
                  end else if (nextX >= X_HI && inBand) begin
                     scoreP1_q  <= satInc(scoreP1_q);
                     serveNeg_q <= 1'b0;
                     state_q    <= GOAL;
                  end else if (hitPaddle) begin
                     vx_q <= dx[12] ? -SPD : SPD;
                     vy_q <= dy[12] ? -SPD : SPD;
                  end else begin
                     if (nextX < X_LO) begin
                        ballX_q <= X_LO[11:0];
                        vx_q    <= -vx_q;
                     end else if (nextX > X_HI) begin
                        ballX_q <= X_HI[11:0];
                        vx_q    <= -vx_q;
                     end else begin
                        ballX_q <= nextX[11:0];
                     end
                     if (nextY < Y_LO) begin
                        ballY_q <= Y_LO[11:0];
                        vy_q    <= -vy_q;
                     end else if (nextY > Y_HI) begin
                        ballY_q <= Y_HI[11:0];
                        vy_q    <= -vy_q;
                     end else begin
                        ballY_q <= nextY[11:0];
                     end
                  end
               end
            end
            GOAL: begin
               ballX_q    <= CX;
               ballY_q    <= CY;
               vx_q       <= '0;
               vy_q       <= '0;
               serveCnt_q <= '0;
               state_q    <= (scoreP1_q == WIN || scoreP2_q == WIN) ? OVER : SERVE;
            end
            OVER: begin
               if (start) begin
                  scoreP1_q  <= '0;
                  scoreP2_q  <= '0;
                  serveCnt_q <= '0;
                  state_q    <= SERVE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign ball_xpos  = ballX_q;
   assign ball_ypos  = ballY_q;
   assign score_p1   = scoreP1_q;
   assign score_p2   = scoreP2_q;
   assign state      = state_q;
   assign frame_tick = frameTick_q;

endmodule

// File: doc/game_ctl.md
Name: game_ctl

Overview:
- Frame-rate game sequencer for the air-hockey pipeline.
- Once per frame it advances the puck position, resolves wall, paddle and goal events, keeps both scores and runs the serve/play/game-over state machine.
- Sits beside the VGA pipeline in the 65 MHz domain. It takes the delayed player position and vblnk from the timing chain, and drives ball position into the ball draw stage.

Parameters:
- FIELD_X_MIN, 32, left wall x (pixels)
- FIELD_X_MAX, 991, right wall x
- FIELD_Y_MIN, 32, top wall y
- FIELD_Y_MAX, 735, bottom wall y
- GOAL_Y_MIN, 304, goal mouth top y (both ends)
- GOAL_Y_MAX, 463, goal mouth bottom y
- BALL_R, 10, puck radius
- PLAYER_R, 20, paddle radius
- SPEED, 4, puck speed per frame per axis (pixels)
- SERVE_FRAMES, 60, frames waited in SERVE
- WIN_SCORE, 7, score that ends the game

Ports:
- clk_in  in  1  65 MHz pixel clock
- rst  in  1  asynchronous, active-low reset
- vblnk_in  in  1  vertical blank from vga_timing
- start  in  1  single-cycle start/restart request
- xpos_in  in  12  player paddle centre x
- ypos_in  in  12  player paddle centre y
- ball_xpos  out  12  puck centre x
- ball_ypos  out  12  puck centre y
- score_p1  out  4  player score (right goal)
- score_p2  out  4  opponent score (left goal)
- state  out  3  IDLE=0, SERVE=1, PLAY=2, GOAL=3, OVER=4
- frame_tick  out  1  one-cycle pulse per frame

Behaviour:
- Interface: single clock clk_in. rst is asynchronous, active-low.
- Reset values:
  - state=IDLE
  - ball=(512,384), velocity=(0,0)
  - scores=0
  - serve counter=0, serve direction=+x
  - frame_tick=0
  - vblnk_prev=1, so no spurious tick if vblnk_in is already high when reset releases.
- Tick:
  - tick = vblnk_in & ~vblnk_prev.
  - frame_tick is a registered copy of tick, one cycle after the vblnk_in rise.
  - All position and score updates occur on the tick cycle. Outputs are registered and visible on the next cycle.
- Arithmetic:
  - Positions are extended to 13-bit signed. vx, vy are 13-bit signed with value ±SPEED.
  - next_x = ball_x + vx, next_y = ball_y + vy.
- IDLE: ball held at centre.
  - start -> SERVE, counter=0.
- SERVE:
  - Ball held at centre; counter increments on each tick.
  - On the tick at which the counter reaches SERVE_FRAMES-1 -> PLAY, with vx = serve direction * SPEED and vy = +SPEED.
- PLAY, evaluated per tick in priority order:
  1. Goal:
     - next_x <= FIELD_X_MIN+BALL_R and GOAL_Y_MIN <= ball_y <= GOAL_Y_MAX -> score_p2++, serve direction = -x, GOAL.
     - next_x >= FIELD_X_MAX-BALL_R with the same y band -> score_p1++, serve direction = +x, GOAL.
  2. Paddle: |next_x - xpos_in| <= BALL_R+PLAYER_R and |next_y - ypos_in| <= BALL_R+PLAYER_R (box test).
     - vx = SPEED * sign(next_x - xpos_in); vy likewise from the y difference. Sign of zero counts as +.
     - Position is not updated this frame.
  3. Walls, x and y axes independent:
     - If next exceeds a wall limit (wall ∓ BALL_R), the position is clamped to that limit and the velocity component negated.
     - Otherwise position = next.
- GOAL (one cycle):
  - Ball recentred, velocity zeroed.
  - Either score == WIN_SCORE -> OVER; else -> SERVE with counter=0.
- OVER:
  - Ball held at centre, scores held.
  - start -> scores cleared, SERVE.
- Scores saturate at WIN_SCORE.
- start is ignored in SERVE, PLAY and GOAL.
- tick and start in the same cycle in IDLE: the state moves to SERVE and the tick is not counted.
- Reset asserted mid-operation returns everything to reset values immediately, without waiting for a clock edge.

Test Plan:
- Reset:
  - Assert rst=0 mid-PLAY -> state=0, ball=(512,384), scores=0 immediately.
  - Release with vblnk_in=1 -> no frame_tick.
- Serve:
  - start, then 60 vblnk rises -> state=2 after the 60th rise.
  - On the next tick ball=(516,388).
- Wall bounce:
  - Force ball_y=723, vy=+4; tick -> ball_y=725, vy=-4.
  - Next tick -> ball_y=721.
- Goal:
  - Ball (985,384), vx=+4; tick -> score_p1=1, state GOAL then SERVE, ball=(512,384).
  - Next serve has vx=+4.
  - Ball (985,200) -> bounce, no score.
- Paddle:
  - Paddle at (540,384), ball at (512,384) moving +x; tick -> vx=-4, ball_x unchanged.
- Win:
  - Drive 7 right-goal events -> score_p1=7, state=4.
  - start -> scores 0, state=1.
